thermostat_ctrl: RTL and testbench



---
 rtl/thermostat_pkg.sv | 29 ++
 rtl/thermostat_ctrl_residency_counter.sv | 39 +++
 rtl/thermostat_ctrl.sv | 122 ++++++++++++
 tb/tb_thermostat_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/thermostat_pkg.sv
// Shared encodings and width helpers for the thermostat controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package thermostat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HEAT = 2'b01,
    ST_COOL = 2'b10
  } state_e;

  // bit 0 enables heating, bit 1 enables cooling
  typedef enum logic [1:0] {
    MODE_OFF       = 2'b00,
    MODE_HEAT_ONLY = 2'b01,
    MODE_COOL_ONLY = 2'b10,
    MODE_AUTO      = 2'b11
  } mode_e;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/thermostat_ctrl_residency_counter.sv
// Saturating residency counter: counts cycles spent in the current state, cleared on a state change.
// Latency: 1 cycle (clr/rst take effect on the next rising edge).
// Backpressure: none; counts every cycle and holds at SAT.
// Ports: clk, rst (sync, active-high), clr (state is changing this edge), cnt (current residency).
module residency_counter #(
  parameter int unsigned W   = 2,
  parameter int unsigned SAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] SAT_V = W'(SAT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != SAT_V) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/thermostat_ctrl.sv
// Heating/cooling controller with hysteresis, minimum run/off times and a 4-way operating mode.
// Latency: 1 cycle; inputs sampled at an edge appear on the registered outputs after that edge.
// Backpressure: none; temperature and mode are sampled every cycle.
// Ports: clk, rst (sync, active-high), temperature (unsigned), mode (OFF/HEAT_ONLY/COOL_ONLY/AUTO),
//        heating, cooling, lockout (start blocked by off-time), state (IDLE/HEAT/COOL).
module thermostat_ctrl
  import thermostat_pkg::*;
#(
  parameter int unsigned TEMP_W      = 5,
  parameter int unsigned HEAT_ON     = 18,
  parameter int unsigned HEAT_OFF    = 20,
  parameter int unsigned COOL_ON     = 22,
  parameter int unsigned COOL_OFF    = 20,
  parameter int unsigned MIN_RUN_CYC = 4,
  parameter int unsigned MIN_OFF_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TEMP_W-1:0] temperature,
  input  logic [1:0]        mode,
  output logic              heating,
  output logic              cooling,
  output logic              lockout,
  output logic [1:0]        state
);

  // Threshold ordering keeps heat and cool demands mutually exclusive.
  if (!(HEAT_ON <= HEAT_OFF && HEAT_OFF <= COOL_ON && COOL_OFF <= COOL_ON &&
        HEAT_ON < COOL_ON && MIN_RUN_CYC >= 1 && MIN_OFF_CYC >= 1)) begin : g_bad_params
    $error("thermostat_ctrl: illegal threshold or timing parameters");
  end

  localparam int unsigned CNT_SAT = max_u(MIN_RUN_CYC, MIN_OFF_CYC) - 1;
  localparam int unsigned CNT_W   = cnt_width(CNT_SAT);

  localparam logic [CNT_W-1:0]  RUN_LAST   = CNT_W'(MIN_RUN_CYC - 1);
  localparam logic [CNT_W-1:0]  OFF_LAST   = CNT_W'(MIN_OFF_CYC - 1);
  localparam logic [TEMP_W-1:0] HEAT_ON_T  = TEMP_W'(HEAT_ON);
  localparam logic [TEMP_W-1:0] HEAT_OFF_T = TEMP_W'(HEAT_OFF);
  localparam logic [TEMP_W-1:0] COOL_ON_T  = TEMP_W'(COOL_ON);
  localparam logic [TEMP_W-1:0] COOL_OFF_T = TEMP_W'(COOL_OFF);

  state_e           state_q, state_d;
  logic             heating_q, heating_d;
  logic             cooling_q, cooling_d;
  logic             lockout_q, lockout_d;
  logic [CNT_W-1:0] cnt;

  logic heat_en, cool_en;
  logic heat_dem, cool_dem;
  logic heat_rel, cool_rel;
  logic run_ok, off_ok;

  assign heat_en  = mode[0];
  assign cool_en  = mode[1];
  assign heat_dem = heat_en && (temperature < HEAT_ON_T);
  assign cool_dem = cool_en && (temperature > COOL_ON_T);
  assign heat_rel = (temperature >= HEAT_OFF_T);
  assign cool_rel = (temperature <= COOL_OFF_T);
  assign run_ok   = (cnt >= RUN_LAST);
  assign off_ok   = (cnt >= OFF_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (heat_dem && off_ok) begin
          state_d = ST_HEAT;
        end else if (cool_dem && off_ok) begin
          state_d = ST_COOL;
        end
      end
      // Losing the enable drops the drive at once, ignoring the minimum run time.
      ST_HEAT: begin
        if (!heat_en || (heat_rel && run_ok)) begin
          state_d = ST_IDLE;
        end
      end
      ST_COOL: begin
        if (!cool_en || (cool_rel && run_ok)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    heating_d = (state_d == ST_HEAT);
    cooling_d = (state_d == ST_COOL);
    lockout_d = (state_d == ST_IDLE) && (heat_dem || cool_dem) && !off_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      heating_q <= 1'b0;
      cooling_q <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      heating_q <= heating_d;
      cooling_q <= cooling_d;
      lockout_q <= lockout_d;
    end
  end

  // Counter restarts on every state change so each state's residency begins at 0.
  residency_counter #(
    .W   (CNT_W),
    .SAT (CNT_SAT)
  ) u_residency_counter (
    .clk (clk),
    .rst (rst),
    .clr (state_d != state_q),
    .cnt (cnt)
  );

  assign heating = heating_q;
  assign cooling = cooling_q;
  assign lockout = lockout_q;
  assign state   = state_q;

endmodule

// File: tb/tb_thermostat_ctrl.sv
// Directed bench for thermostat_ctrl with hand-computed expected outputs.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_thermostat_ctrl;
  import thermostat_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] temperature;
  logic [1:0] mode;
  logic       heating;
  logic       cooling;
  logic       lockout;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  thermostat_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .temperature (temperature),
    .mode        (mode),
    .heating     (heating),
    .cooling     (cooling),
    .lockout     (lockout),
    .state       (state)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Advance one edge, then compare {heating,cooling,lockout,state} and exclusivity.
  task automatic step(input string tag, input logic h, input logic c, input logic l,
                      input logic [1:0] st);
    @(posedge clk);
    #1;
    chk(tag, {3'b000, heating, cooling, lockout, state}, {3'b000, h, c, l, st});
    chk({tag, "_excl"}, {7'd0, heating & cooling}, 8'd0);
  endtask

  initial begin
    rst         = 1'b1;
    mode        = MODE_AUTO;
    temperature = 5'd20;
    step("reset0", 0, 0, 0, 2'b00);
    step("reset1", 0, 0, 0, 2'b00);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step("idle_20", 0, 0, 0, 2'b00);

    // Fresh reset with a cold room: off-time blocks the start for 3 cycles.
    rst = 1'b1;
    step("reset2", 0, 0, 0, 2'b00);
    step("reset3", 0, 0, 0, 2'b00);
    rst         = 1'b0;
    temperature = 5'd15;
    for (int i = 0; i < 3; i++) step("lock_heat", 0, 0, 1, 2'b00);
    step("heat_start", 1, 0, 0, 2'b01);
    step("heat_hold", 1, 0, 0, 2'b01);

    // Release condition met early; minimum run holds the heater.
    temperature = 5'd21;
    step("heat_minrun0", 1, 0, 0, 2'b01);
    step("heat_minrun1", 1, 0, 0, 2'b01);
    step("heat_release", 0, 0, 0, 2'b00);

    temperature = 5'd25;
    for (int i = 0; i < 3; i++) step("lock_cool", 0, 0, 1, 2'b00);
    step("cool_start", 0, 1, 0, 2'b10);
    temperature = 5'd21;
    step("cool_hyst0", 0, 1, 0, 2'b10);
    step("cool_hyst1", 0, 1, 0, 2'b10);
    temperature = 5'd20;
    step("cool_minrun", 0, 1, 0, 2'b10);
    step("cool_release", 0, 0, 0, 2'b00);

    // Threshold equality never starts a drive.
    temperature = 5'd18;
    for (int i = 0; i < 6; i++) step("bnd_heat_on", 0, 0, 0, 2'b00);
    temperature = 5'd22;
    for (int i = 0; i < 6; i++) step("bnd_cool_on", 0, 0, 0, 2'b00);
    temperature = 5'd31;
    step("hot_max", 0, 1, 0, 2'b10);

    // Mode change drops cooling immediately despite short residency.
    mode = MODE_HEAT_ONLY;
    step("mode_cool_drop", 0, 0, 0, 2'b00);
    temperature = 5'd10;
    for (int i = 0; i < 3; i++) step("lock_after_cool", 0, 0, 1, 2'b00);
    step("heat_after_idle", 1, 0, 0, 2'b01);

    mode = MODE_OFF;
    step("mode_off", 0, 0, 0, 2'b00);
    mode = MODE_HEAT_ONLY;
    for (int i = 0; i < 3; i++) step("lock_after_off", 0, 0, 1, 2'b00);
    step("heat_again", 1, 0, 0, 2'b01);
    step("heat_again_hold", 1, 0, 0, 2'b01);

    rst = 1'b1;
    step("rst_mid_heat", 0, 0, 0, 2'b00);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("lock_after_rst", 0, 0, 1, 2'b00);
    step("heat_after_rst", 1, 0, 0, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
